// File: rtl/simd_fir_pkg.sv
// Shared types, default sizes and the output saturation helper for the SIMD FIR engine.
package simd_fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int DEF_LANES  = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAPS   = 32;
    localparam int DEF_SHIFT  = 15;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned    w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/simd_fir_engine_lane.sv
// One lane of the engine: signed multiply-accumulate, then shift and saturate into a held result.
module fir_lane_mac
    import simd_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_clr_i,
    input  logic                     acc_en_i,
    input  logic                     res_load_i,
    input  logic signed [DATA_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] samp_i,
    output logic signed [DATA_W-1:0] res_o
);

    // Full-precision sum of TAPS products cannot overflow this width.
    localparam int ACC_W = 2 * DATA_W + $clog2(TAPS);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [63:0]         shifted;
    logic signed [DATA_W-1:0]   res_q;
    logic signed [DATA_W-1:0]   res_d;

    assign prod = coef_i * samp_i;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
        end
    end

    always_comb begin
        shifted = $signed({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q}) >>> SHIFT;
        res_d   = res_q;
        if (res_load_i) begin
            res_d = DATA_W'(saturate(shifted, DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/simd_fir_engine.sv
// Vector FIR engine: LANES outputs per input vector, one tap per cycle across all lanes,
// sharing one sample history and coefficient table.
module simd_fir_engine
    import simd_fir_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    in_vec,
    input  logic [$clog2(TAPS+1)-1:0]  num_taps,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_W-1:0]    out_vec,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [DATA_W-1:0]          coef_data,
    input  logic                       clear,
    output logic                       busy
);

    localparam int NT_W = $clog2(TAPS + 1);
    localparam int K_W  = $clog2(TAPS);
    localparam int HIST = TAPS - 1 + LANES;
    localparam int HI_W = $clog2(HIST);

    state_e                   state_q;
    state_e                   state_d;
    logic [K_W-1:0]           k_q;
    logic [K_W-1:0]           k_d;
    logic [NT_W-1:0]          nt_q;
    logic [NT_W-1:0]          nt_d;
    logic [NT_W-1:0]          nt_new;
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic                     hs;
    logic                     last_tap;
    logic signed [DATA_W-1:0] hist_q [HIST];
    logic signed [DATA_W-1:0] hist_d [HIST];
    logic signed [DATA_W-1:0] coef_q [TAPS];

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign hs        = in_valid && in_ready;
    assign last_tap  = (NT_W'(k_q) == nt_q - NT_W'(1));

    always_comb begin
        nt_new = num_taps;
        if (num_taps == '0) begin
            nt_new = NT_W'(1);
        end else if (num_taps > NT_W'(TAPS)) begin
            nt_new = NT_W'(TAPS);
        end
    end

    // OUT spends its first cycle loading the lane results, which gives latency nt+1.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        nt_d        = nt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = MAC;
                    k_d     = '0;
                    nt_d    = nt_new;
                end
            end
            MAC: begin
                k_d = k_q + K_W'(1);
                if (last_tap) begin
                    state_d = OUT;
                    k_d     = '0;
                end
            end
            OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Clear lands before the append so a same-cycle vector starts from empty history.
    always_comb begin
        hist_d = hist_q;
        if (state_q == IDLE) begin
            if (clear) begin
                for (int i = 0; i < HIST; i++) hist_d[i] = '0;
            end
            if (hs) begin
                for (int i = 0; i < TAPS - 1; i++) begin
                    hist_d[i] = clear ? '0 : hist_q[i + LANES];
                end
                for (int l = 0; l < LANES; l++) begin
                    hist_d[TAPS - 1 + l] = in_vec[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            nt_q        <= NT_W'(1);
            out_valid_q <= 1'b0;
            for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nt_q        <= nt_d;
            out_valid_q <= out_valid_d;
            hist_q      <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else if (coef_we && (state_q == IDLE)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Lane l holds sample index TAPS-1+l; tap k reaches k samples further back.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [HI_W-1:0]          idx;
        logic signed [DATA_W-1:0] res;

        assign idx = HI_W'(TAPS - 1 + l) - HI_W'(k_q);

        fir_lane_mac #(
            .DATA_W (DATA_W),
            .TAPS   (TAPS),
            .SHIFT  (SHIFT)
        ) u_mac (
            .clk        (clk),
            .reset      (reset),
            .acc_clr_i  (hs),
            .acc_en_i   (state_q == MAC),
            .res_load_i ((state_q == OUT) && !out_valid_q),
            .coef_i     (coef_q[k_q]),
            .samp_i     (hist_q[idx]),
            .res_o      (res)
        );

        assign out_vec[l*DATA_W +: DATA_W] = res;
    end

endmodule

// File: tb/tb_simd_fir_engine.sv
// Directed bench for simd_fir_engine: impulse, history carry, clear, tap clamping,
// busy-time coefficient writes, saturation, backpressure and mid-MAC reset.
module tb_simd_fir_engine;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int TAPS   = 32;
    localparam int VW     = LANES * DATA_W;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic              coef_we   = 1'b0;
    logic              clear     = 1'b0;
    logic [VW-1:0]     in_vec    = '0;
    logic [5:0]        num_taps  = '0;
    logic [4:0]        coef_addr = '0;
    logic [DATA_W-1:0] coef_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              busy;
    logic [VW-1:0]     out_vec;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    simd_fir_engine #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .SHIFT  (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .num_taps  (num_taps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clear     (clear),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [VW-1:0] vset(input logic [VW-1:0] v, input int lane,
                                           input logic [DATA_W-1:0] val);
        logic [VW-1:0] r;
        r = v;
        r[lane*DATA_W +: DATA_W] = val;
        return r;
    endfunction

    function automatic logic [VW-1:0] vfill(input logic [DATA_W-1:0] val);
        return {LANES{val}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int addr, input logic [DATA_W-1:0] data);
        coef_we   = 1'b1;
        coef_addr = 5'(addr);
        coef_data = data;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic hs(input logic [VW-1:0] vec, input int nt, input logic clr);
        in_vec   = vec;
        num_taps = 6'(nt);
        clear    = clr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [VW-1:0] imp;
    logic [VW-1:0] exp_imp;
    int            lat;
    logic          seen;

    initial begin
        imp     = vset('0, 0, 16'h4000);
        exp_imp = vset(vset(vset(vset('0, 0, 16'h0800), 1, 16'h1000), 2, 16'h1800), 3, 16'h2000);

        repeat (3) tick();
        reset = 1'b1;
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_out_vec", out_vec, '0);

        for (int k = 0; k < 4; k++) wcoef(k, DATA_W'((k + 1) * 16'h1000));
        wcoef(9, 16'h2000);

        // Impulse, then hold the result under backpressure
        hs(imp, 4, 1'b0);
        wait_out(lat);
        check("imp_lat", VW'(lat), VW'(5));
        check("imp_vec", out_vec, exp_imp);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid", VW'(out_valid), VW'(1));
            check("bp_vec", out_vec, exp_imp);
            check("bp_in_ready", VW'(in_ready), VW'(0));
        end
        pop();
        check("bp_idle", VW'(in_ready), VW'(1));
        check("bp_valid_drop", VW'(out_valid), VW'(0));

        // Zero vector: only coef[9] reaches the impulse, through lane 1
        hs('0, 16, 1'b0);
        wait_out(lat);
        check("carry_lat", VW'(lat), VW'(17));
        check("carry_vec", out_vec, vset('0, 1, 16'h1000));
        pop();

        // Clear with handshake removes that history
        hs(imp, 4, 1'b1);
        wait_out(lat);
        pop();
        hs('0, 16, 1'b1);
        wait_out(lat);
        check("clr_hs_vec", out_vec, '0);
        pop();

        // Clear alone while idle
        hs(imp, 4, 1'b0);
        wait_out(lat);
        pop();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        hs('0, 16, 1'b0);
        wait_out(lat);
        check("clr_idle_vec", out_vec, '0);
        pop();

        hs(imp, 0, 1'b1);
        wait_out(lat);
        check("nt0_lat", VW'(lat), VW'(2));
        check("nt0_vec", out_vec, vset('0, 0, 16'h0800));
        pop();

        hs(imp, 40, 1'b1);
        wait_out(lat);
        check("nt40_lat", VW'(lat), VW'(33));
        check("nt40_vec", out_vec, exp_imp);
        pop();

        // Coefficient write while busy must be dropped
        hs(imp, 8, 1'b1);
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 16'h7FFF;
        tick();
        check("mac_busy", VW'(busy), VW'(1));
        tick();
        coef_we = 1'b0;
        wait_out(lat);
        pop();
        hs(imp, 4, 1'b1);
        wait_out(lat);
        check("we_busy_vec", out_vec, exp_imp);
        pop();

        // Write and handshake in the same cycle: new coef[0] is used
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 16'h2000;
        hs(imp, 4, 1'b1);
        wait_out(lat);
        check("we_hs_vec", out_vec, vset(exp_imp, 0, 16'h1000));
        pop();

        // Saturation at both rails
        for (int k = 0; k < TAPS; k++) wcoef(k, 16'h7FFF);
        for (int v = 0; v < 5; v++) begin
            hs(vfill(16'h7FFF), 32, v == 0);
            wait_out(lat);
            if (v == 4) begin
                check("sat_pos_lat", VW'(lat), VW'(33));
                check("sat_pos_vec", out_vec, vfill(16'h7FFF));
            end
            pop();
        end
        for (int v = 0; v < 5; v++) begin
            hs(vfill(16'h8000), 32, v == 0);
            wait_out(lat);
            if (v == 4) check("sat_neg_vec", out_vec, vfill(16'h8000));
            pop();
        end

        // Reset in the third MAC cycle abandons the result
        hs(imp, 8, 1'b1);
        tick();
        tick();
        check("pre_rst_ready", VW'(in_ready), VW'(0));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_ready", VW'(in_ready), VW'(1));
        check("mid_rst_valid", VW'(out_valid), VW'(0));
        check("mid_rst_busy", VW'(busy), VW'(0));
        check("mid_rst_vec", out_vec, '0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            seen = seen | out_valid;
        end
        check("mid_rst_no_valid", VW'(seen), VW'(0));

        // Coefficients were reset, so an impulse now yields nothing
        hs(imp, 4, 1'b0);
        wait_out(lat);
        check("coef_rst_lat", VW'(lat), VW'(5));
        check("coef_rst_vec", out_vec, '0);
        pop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
